// File: rtl/six502_pkg.sv
// Shared encodings for the 6502 opcode-fetch path: interrupt sources,
// the injected BRK opcode and the fetch sequencer states.
package six502_pkg;

  localparam logic [7:0] BRK_OPCODE = 8'h00;

  typedef enum logic [1:0] {
    INT_NONE = 2'b00,
    INT_IRQ  = 2'b01,
    INT_NMI  = 2'b10,
    INT_RST  = 2'b11
  } int_src_t;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Bus/decoder/IR-side signals of the opcode-fetch sequencer. The master
// modport is the surrounding core; the slave modport is the sequencer.
interface fetch_seq_if;
  logic       rdy;
  logic [7:0] data;
  logic       last_cycle;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  logic       sync;
  logic [7:0] opcode;
  logic [2:0] tcount;
  logic [1:0] int_src;
  logic       seq_err;

  modport master (
    output rdy, data, last_cycle, nmi_n, irq_n, i_flag,
    input  sync, opcode, tcount, int_src, seq_err
  );

  modport slave (
    input  rdy, data, last_cycle, nmi_n, irq_n, i_flag,
    output sync, opcode, tcount, int_src, seq_err
  );
endinterface

// File: rtl/fetch_seq_nmi_edge_det.sv
// Falling-edge latch for the NMI pin. Runs every clock regardless of rdy;
// a new edge in the same cycle as a take keeps the request pending.
module nmi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic take,
  output logic pend
);

  logic nmi_prev;
  logic edge_seen;

  assign edge_seen = nmi_prev & ~nmi_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev <= 1'b1;
      pend     <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      if (edge_seen) begin
        pend <= 1'b1;
      end else if (take) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Opcode-fetch sequencer: produces sync, tracks T0..TMAX and injects BRK
// for reset, NMI and IRQ while reporting which source caused it.
module fetch_seq
  import six502_pkg::*;
#(
  parameter logic [7:0] BRK_OP = BRK_OPCODE,
  parameter int          TMAX   = 7
) (
  input  logic        clk,
  input  logic        rst,
  fetch_seq_if.slave  bus
);

  fetch_state_t state_q, state_d;
  logic [2:0]   tcount_q, tcount_d;
  logic [7:0]   opcode_q, opcode_d;
  int_src_t     int_src_q, int_src_d;
  logic         force_inj_q, force_inj_d;
  logic         seq_err_q, seq_err_d;
  logic         nmi_take;
  logic         nmi_pend;

  nmi_edge_det u_nmi_edge_det (
    .clk   (clk),
    .rst   (rst),
    .nmi_n (bus.nmi_n),
    .take  (nmi_take),
    .pend  (nmi_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      tcount_q    <= 3'd0;
      opcode_q    <= BRK_OP;
      int_src_q   <= INT_RST;
      force_inj_q <= 1'b1;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcount_q    <= tcount_d;
      opcode_q    <= opcode_d;
      int_src_q   <= int_src_d;
      force_inj_q <= force_inj_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Interrupts are only sampled on the final cycle of an instruction; the
  // chosen source is held until the following fetch injects BRK.
  always_comb begin
    state_d     = state_q;
    tcount_d    = tcount_q;
    opcode_d    = opcode_q;
    int_src_d   = int_src_q;
    force_inj_d = force_inj_q;
    seq_err_d   = seq_err_q;
    nmi_take    = 1'b0;

    if (bus.rdy) begin
      unique case (state_q)
        FETCH: begin
          opcode_d    = force_inj_q ? BRK_OP : bus.data;
          if (!force_inj_q) begin
            int_src_d = INT_NONE;
          end
          force_inj_d = 1'b0;
          state_d     = EXEC;
          tcount_d    = 3'd1;
        end
        EXEC: begin
          if (bus.last_cycle) begin
            state_d  = FETCH;
            tcount_d = 3'd0;
            if (nmi_pend) begin
              force_inj_d = 1'b1;
              int_src_d   = INT_NMI;
              nmi_take    = 1'b1;
            end else if (!bus.irq_n && !bus.i_flag) begin
              force_inj_d = 1'b1;
              int_src_d   = INT_IRQ;
            end else begin
              force_inj_d = 1'b0;
            end
          end else if (tcount_q == 3'(TMAX)) begin
            seq_err_d   = 1'b1;
            state_d     = FETCH;
            tcount_d    = 3'd0;
            force_inj_d = 1'b0;
          end else begin
            tcount_d = tcount_q + 3'd1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.sync    = (state_q == FETCH);
  assign bus.opcode  = opcode_q;
  assign bus.tcount  = tcount_q;
  assign bus.int_src = int_src_q;
  assign bus.seq_err = seq_err_q;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Opcode-fetch sequencer for the 6502 core. It generates the sync strobe that the instruction register samples, and tracks the instruction cycle count T0..T7. On reset, NMI or IRQ it forces the BRK opcode in place of bus data and reports the interrupt source so the vector logic picks the right address. It sits between the data bus, the decode ROM (which supplies last_cycle) and the instruction register.

Parameters:
BRK_OP, 8'h00, opcode injected for reset/NMI/IRQ sequences
TMAX, 7, highest legal cycle count; reaching it without last_cycle is a sequencing error

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
rdy  in  1  bus ready; low stalls all state (no advance, no latching)
data  in  8  data bus during opcode fetch
last_cycle  in  1  from decoder: current cycle is final cycle of the instruction
nmi_n  in  1  NMI pin, active low, edge-triggered
irq_n  in  1  IRQ pin, active low, level-sensitive
i_flag  in  1  processor status I bit (1 = IRQ masked)
sync  out  1  high during opcode-fetch cycle (T0)
opcode  out  8  registered opcode: data or BRK_OP
tcount  out  3  current cycle number, 0 = fetch
int_src  out  2  source of the current BRK: 00 none/soft BRK, 01 IRQ, 10 NMI, 11 RESET
seq_err  out  1  sticky: tcount hit TMAX with no last_cycle

Behaviour:
- Everything is decided on the clk rising edge. rst is sampled synchronously and overrides all other inputs.
- Reset values: state=FETCH, sync=1, tcount=0, opcode=BRK_OP, int_src=11, force=1 (inject pending), nmi_pend=0, nmi_prev=1, seq_err=0.
- States: FETCH (sync=1, tcount=0) and EXEC (sync=0, tcount 1..TMAX).
- FETCH with rdy=1:
  - opcode <= force ? BRK_OP : data.
  - If force=0, int_src <= 00. If force=1, int_src keeps the value latched at the decision point.
  - Clear force. Go to EXEC with tcount=1.
- FETCH with rdy=0: hold all state; sync stays 1.
- EXEC with rdy=1:
  - last_cycle=1: go to FETCH, tcount=0. This is the decision point: sample interrupts, priority NMI > IRQ.
  - If nmi_pend: force=1, int_src=10, clear nmi_pend.
  - Else if irq_n=0 and i_flag=0: force=1, int_src=01.
  - Else force=0.
  - last_cycle=0 and tcount<TMAX: tcount+1.
  - last_cycle=0 and tcount=TMAX: set seq_err, go to FETCH, force=0. This recovers the sequencer; seq_err stays set until rst.
- EXEC with rdy=0: hold.
- NMI edge detect runs every clk regardless of rdy:
  - nmi_prev <= nmi_n.
  - nmi_pend set when nmi_prev=1 and nmi_n=0.
  - If a new edge occurs in the same cycle pend is cleared by the decision point, pend stays set. Set wins over clear.
- IRQ is not latched; only the level at the decision point counts.
- Reset mid-instruction: immediate return to the reset values above. The next fetch injects BRK_OP with int_src=11.
- Latency: sync rises the cycle after the cycle in which last_cycle and rdy are both high. opcode is valid the cycle after sync with rdy=1.

Decomposition:
- Package six502_pkg: int_src encodings (INT_NONE, INT_IRQ, INT_NMI, INT_RST), BRK opcode constant, state enum {FETCH, EXEC}.
- One sub-module, nmi_edge_det: sync-reset falling-edge latch with take/clear input, set-priority.

Test Plan:
- Reset, then rst=0, rdy=1, data=8'hA9 -> first fetch yields opcode=8'h00, int_src=11; sync=1 in cycle 0 only.
- With no interrupts, opcode 8'hEA and last_cycle on T1 -> sync pattern 1,0,1,0; opcode=8'hEA, int_src=00.
- Pulse nmi_n low for 1 cycle mid-instruction while irq_n=0 and i_flag=0 -> next fetch opcode=8'h00, int_src=10; the following fetch is IRQ (int_src=01).
- irq_n=0 with i_flag=1 -> no injection, opcode=data. Hold rdy=0 for 3 cycles in FETCH -> sync held at 1, opcode unchanged, then data latched.
- Never assert last_cycle -> tcount counts 1..7, seq_err=1, returns to FETCH. Apply rst -> seq_err=0.
- NMI edge in the same cycle an NMI is taken -> a second NMI BRK follows the next instruction.
